// File: rtl/alu_pkg.sv
// Shared types for the switch-driven ALU and its operand-entry front end.
//   entry_state_t : operand-entry FSM states; the encoding is shown on the step LEDs
//   alu_op_t      : ALU opcode, also used by the ALU decode
package alu_pkg;

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_F     = 2'd2,
    S_ISSUE = 2'd3
  } entry_state_t;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_ADD = 2'd2,
    OP_SUB = 2'd3
  } alu_op_t;

endpackage

// File: rtl/switch_debounce.sv
// Front-panel switch debouncer.
// A raw level change is accepted only after DEBOUNCE consecutive cycles of
// disagreement with the accepted level. A registered one-cycle pulse follows
// every accepted 0->1 change.
// Ports:
//   clk_2      in  system clock
//   reset      in  synchronous, active-high reset
//   raw        in  raw switch level (may bounce)
//   level      out debounced level
//   rise_pulse out one-cycle pulse, one cycle after level rises
module switch_debounce #(
  parameter int DEBOUNCE = 2
) (
  input  logic clk_2,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             level_prev_q;
  logic             pulse_q;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      level_prev_q <= level_q;
      // Pulse lags the level change by one cycle so it is a clean register output.
      pulse_q      <= level_q & ~level_prev_q;
      if (raw != level_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
          level_q <= raw;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        // Any return to agreement restarts the count, so short glitches are dropped.
        cnt_q <= '0;
      end
    end
  end

  assign level      = level_q;
  assign rise_pulse = pulse_q;

endmodule

// File: rtl/alu_operand_entry.sv
// Operand-entry front end for the switch-driven ALU.
// The user sets data_in and presses enter three times (A, B, opcode); the
// block then holds one command on a valid/ready handshake until the ALU
// accepts it. step shows which field is expected next.
// Ports:
//   clk_2     in  system clock
//   reset     in  synchronous, active-high reset
//   enter_raw in  raw enter switch level
//   data_in   in  value captured at the current step (opcode uses [1:0])
//   cmd_ready in  ALU accepts the command this cycle
//   cmd_valid out command valid
//   cmd_a     out operand A
//   cmd_b     out operand B
//   cmd_f     out opcode (0 AND, 1 OR, 2 ADD, 3 SUB)
//   step      out 0 expect A, 1 expect B, 2 expect F, 3 issuing
module alu_operand_entry
  import alu_pkg::*;
#(
  parameter int NBITS    = 4,
  parameter int DEBOUNCE = 2
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             enter_raw,
  input  logic [NBITS-1:0] data_in,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [NBITS-1:0] cmd_a,
  output logic [NBITS-1:0] cmd_b,
  output logic [1:0]       cmd_f,
  output logic [1:0]       step
);

  logic enter_db;
  logic enter_pulse;

  switch_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_enter_db (
    .clk_2     (clk_2),
    .reset     (reset),
    .raw       (enter_raw),
    .level     (enter_db),
    .rise_pulse(enter_pulse)
  );

  entry_state_t     state_q, state_d;
  logic [NBITS-1:0] a_q;
  logic [NBITS-1:0] b_q;
  alu_op_t          f_q;
  logic             valid_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_A:     if (enter_pulse) state_d = S_B;
      S_B:     if (enter_pulse) state_d = S_F;
      S_F:     if (enter_pulse) state_d = S_ISSUE;
      // valid_q is always set in S_ISSUE, so ready alone completes the transfer.
      S_ISSUE: if (valid_q && cmd_ready) state_d = S_A;
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= OP_AND;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_A: if (enter_pulse) a_q <= data_in;
        S_B: if (enter_pulse) b_q <= data_in;
        S_F: begin
          if (enter_pulse) begin
            f_q     <= alu_op_t'(data_in[1:0]);
            valid_q <= 1'b1;
          end
        end
        // Fields stay frozen while issuing and keep their values afterwards.
        S_ISSUE: if (valid_q && cmd_ready) valid_q <= 1'b0;
        default: valid_q <= 1'b0;
      endcase
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_a     = a_q;
  assign cmd_b     = b_q;
  assign cmd_f     = f_q;
  assign step      = state_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
module tb_alu_operand_entry;

  localparam int NBITS = 4;

  logic             clk_2 = 1'b0;
  logic             reset;
  logic             enter_raw;
  logic [NBITS-1:0] data_in;
  logic             cmd_ready;
  logic             cmd_valid;
  logic [NBITS-1:0] cmd_a;
  logic [NBITS-1:0] cmd_b;
  logic [1:0]       cmd_f;
  logic [1:0]       step;

  // Second instance with a longer debounce window.
  logic             enter4;
  logic [NBITS-1:0] data4;
  logic             valid4;
  logic [NBITS-1:0] a4;
  logic [NBITS-1:0] b4;
  logic [1:0]       f4;
  logic [1:0]       step4;

  always #5 clk_2 = ~clk_2;

  alu_operand_entry #(.NBITS(NBITS), .DEBOUNCE(2)) dut (
    .clk_2    (clk_2),
    .reset    (reset),
    .enter_raw(enter_raw),
    .data_in  (data_in),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .cmd_f    (cmd_f),
    .step     (step)
  );

  alu_operand_entry #(.NBITS(NBITS), .DEBOUNCE(4)) dut4 (
    .clk_2    (clk_2),
    .reset    (reset),
    .enter_raw(enter4),
    .data_in  (data4),
    .cmd_ready(1'b1),
    .cmd_valid(valid4),
    .cmd_a    (a4),
    .cmd_b    (b4),
    .cmd_f    (f4),
    .step     (step4)
  );

  typedef struct {
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic [1:0]       f;
    int               hold;   // cycles cmd_ready stays low once valid
  } vec_t;

  typedef struct {
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic [1:0]       f;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;
  exp_t sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  // Scoreboard: every accepted transfer must match the oldest pushed command.
  always @(negedge clk_2) begin
    if (!reset && cmd_valid) valid_cnt++;
    if (!reset && cmd_valid && cmd_ready) begin
      if (sb_q.size() == 0) begin
        chk("xfer_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("xfer_a", int'(cmd_a), int'(e.a));
        chk("xfer_b", int'(cmd_b), int'(e.b));
        chk("xfer_f", int'(cmd_f), int'(e.f));
      end
    end
  end

  task automatic press(input logic [NBITS-1:0] d);
    data_in   = d;
    enter_raw = 1'b1;
    tick(4);
    enter_raw = 1'b0;
    tick(4);
  endtask

  task automatic run_vec(input vec_t v);
    int   v0;
    bit   seen;
    exp_t e;
    cmd_ready = (v.hold == 0);
    chk("vec_step0", int'(step), 0);
    press(v.a);
    chk("vec_step1", int'(step), 1);
    press(v.b);
    chk("vec_step2", int'(step), 2);
    e.a = v.a; e.b = v.b; e.f = v.f;
    sb_q.push_back(e);
    v0        = valid_cnt;
    data_in   = {2'b00, v.f};
    enter_raw = 1'b1;
    seen      = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick(1);
      if (cmd_valid) seen = 1;
    end
    chk("vec_valid_seen", int'(seen), 1);
    chk("vec_step3", int'(step), 3);
    if (v.hold == 0) begin
      tick(1);
      chk("vec_valid_drop", int'(cmd_valid), 0);
      chk("vec_step_back", int'(step), 0);
      chk("vec_valid_cycles", valid_cnt - v0, 1);
      enter_raw = 1'b0;
      tick(4);
    end else begin
      enter_raw = 1'b0;
      for (int i = 0; i < v.hold; i++) begin
        // A second press while issuing must not disturb the held command.
        if (i == 3) begin
          enter_raw = 1'b1;
          data_in   = ~v.a;
        end
        tick(1);
        chk("hold_valid", int'(cmd_valid), 1);
        chk("hold_a", int'(cmd_a), int'(v.a));
        chk("hold_f", int'(cmd_f), int'(v.f));
      end
      chk("hold_step", int'(step), 3);
      chk("hold_b", int'(cmd_b), int'(v.b));
      enter_raw = 1'b0;
      cmd_ready = 1'b1;
      tick(1);
      chk("hold_xfer_drop", int'(cmd_valid), 0);
      chk("hold_step_back", int'(step), 0);
      tick(4);
    end
    chk("vec_fields_kept_a", int'(cmd_a), int'(v.a));
  endtask

  vec_t vecs[3];

  initial begin
    int v0;

    vecs[0] = '{a: 4'd5,  b: 4'd3,  f: 2'd2, hold: 0};
    vecs[1] = '{a: 4'd7,  b: 4'd1,  f: 2'd3, hold: 8};
    vecs[2] = '{a: 4'hF,  b: 4'h0,  f: 2'd1, hold: 0};

    reset = 1'b1; enter_raw = 1'b0; data_in = '0; cmd_ready = 1'b0;
    enter4 = 1'b0; data4 = '0;
    tick(2);
    reset = 1'b0;
    chk("rst_step", int'(step), 0);
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_a", int'(cmd_a), 0);
    chk("rst_b", int'(cmd_b), 0);
    chk("rst_f", int'(cmd_f), 0);

    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // Glitches of one cycle never reach the FSM.
    reset = 1'b1; tick(1); reset = 1'b0;
    data_in = 4'd6;
    enter_raw = 1'b1; tick(1); enter_raw = 1'b0; tick(1);
    enter_raw = 1'b1; tick(1); enter_raw = 1'b0; tick(6);
    chk("bounce_step", int'(step), 0);
    chk("bounce_a", int'(cmd_a), 0);

    // Long hold gives one pulse; a second press captures B only.
    data_in = 4'd6; enter_raw = 1'b1; tick(20);
    chk("long_step", int'(step), 1);
    chk("long_a", int'(cmd_a), 6);
    enter_raw = 1'b0; tick(4);
    press(4'd9);
    chk("long2_step", int'(step), 2);
    chk("long2_b", int'(cmd_b), 9);

    // Reset in S_F aborts the sequence.
    reset = 1'b1; tick(1); reset = 1'b0;
    cmd_ready = 1'b1;
    press(4'd9);
    press(4'd4);
    chk("abort_pre_step", int'(step), 2);
    v0 = valid_cnt;
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("abort_step", int'(step), 0);
    chk("abort_a", int'(cmd_a), 0);
    chk("abort_b", int'(cmd_b), 0);
    tick(10);
    chk("abort_no_valid", valid_cnt - v0, 0);

    // DEBOUNCE=4 latency: stable rise at edge t, pulse after t+4, step moves after t+5.
    data4 = 4'd3;
    enter4 = 1'b1;
    tick(4);
    chk("db4_t3_step", int'(step4), 0);
    tick(1);
    chk("db4_t4_step", int'(step4), 0);
    tick(1);
    chk("db4_t5_step", int'(step4), 1);
    chk("db4_a", int'(a4), 3);
    enter4 = 1'b0; tick(6);
    enter4 = 1'b1; data4 = 4'd8; tick(3);
    enter4 = 1'b0; tick(8);
    chk("db4_glitch_step", int'(step4), 1);
    chk("db4_glitch_b", int'(b4), 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
